// File: rtl/button_debounce_sync.sv
// Button conditioner: 2-flop synchronizer, per-bit counter debounce,
// and registered one-cycle press/release pulses.
module button_debounce_sync #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] key_in,
  output logic [WIDTH-1:0] button_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic             any_event
);

  localparam int CW =
    ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IDLE = {WIDTH{ACTIVE_LOW}};

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] raw_s;
  logic [WIDTH-1:0] btn_q, btn_d;
  logic [WIDTH-1:0] press_q, press_d;
  logic [WIDTH-1:0] rel_q, rel_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  // Synchronizer holds raw pin levels; polarity is folded in after it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= IDLE;
      sync_q <= IDLE;
    end else begin
      meta_q <= key_in;
      sync_q <= meta_q;
    end
  end

  assign raw_s = sync_q ^ IDLE;

  always_comb begin
    btn_d   = btn_q;
    press_d = '0;
    rel_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (raw_s[i] != btn_q[i]) begin
        if (cnt_q[i] == TERM) begin
          btn_d[i]   = raw_s[i];
          press_d[i] = raw_s[i];
          rel_d[i]   = ~raw_s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_q   <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      btn_q   <= btn_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign button_out    = btn_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign any_event     = (|press_q) | (|rel_q);

endmodule

// File: tb/tb_button_debounce_sync.sv
// Scoreboard bench: active-low and active-high instances share one
// stimulus (inverted pins) and one queue of expected output events.
module tb_button_debounce_sync;

  logic       clk;
  logic       reset_n;
  logic [1:0] key_al;
  logic [1:0] key_ah;

  logic [1:0] bo0, pp0, rp0;
  logic       ae0;
  logic [1:0] bo1, pp1, rp1;
  logic       ae1;

  assign key_ah = ~key_al;

  button_debounce_sync #(
    .WIDTH(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .reset_n(reset_n), .key_in(key_al),
    .button_out(bo0), .press_pulse(pp0),
    .release_pulse(rp0), .any_event(ae0)
  );

  button_debounce_sync #(
    .WIDTH(2), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1'b0)
  ) dut_ah (
    .clk(clk), .reset_n(reset_n), .key_in(key_ah),
    .button_out(bo1), .press_pulse(pp1),
    .release_pulse(rp1), .any_event(ae1)
  );

  typedef struct {
    int         cyc;
    logic [1:0] bo;
    logic [1:0] pp;
    logic [1:0] rp;
    logic       ae;
  } ev_t;

  ev_t sb[$];
  int  cyc;
  int  vectors;
  int  miscompares;
  bit  mon_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int c, input logic [1:0] bo,
                           input logic [1:0] pp, input logic [1:0] rp,
                           input logic ae);
    ev_t e;
    e.cyc = c;
    e.bo  = bo;
    e.pp  = pp;
    e.rp  = rp;
    e.ae  = ae;
    sb.push_back(e);
  endtask

  task automatic chk_ev(input string nm, input ev_t e, input int c,
                        input logic [1:0] bo, input logic [1:0] pp,
                        input logic [1:0] rp, input logic ae);
    vectors++;
    if (c !== e.cyc || bo !== e.bo || pp !== e.pp ||
        rp !== e.rp || ae !== e.ae) begin
      miscompares++;
      $display("FAIL %s: got cyc=%0d bo=%b pp=%b rp=%b ae=%b, want cyc=%0d bo=%b pp=%b rp=%b ae=%b",
               nm, c, bo, pp, rp, ae, e.cyc, e.bo, e.pp, e.rp, e.ae);
    end
  endtask

  task automatic chk_zero(input string nm);
    vectors++;
    if ({bo0, pp0, rp0, ae0, bo1, pp1, rp1, ae1} !== 14'd0) begin
      miscompares++;
      $display("FAIL %s: got al bo=%b pp=%b rp=%b ae=%b ah bo=%b pp=%b rp=%b ae=%b, want all 0",
               nm, bo0, pp0, rp0, ae0, bo1, pp1, rp1, ae1);
    end
  endtask

  // Monitor: any pulse, any_event, or button_out change is an event.
  initial begin : monitor
    logic [1:0] prev0, prev1;
    bit         act;
    ev_t        e;
    prev0 = 2'b00;
    prev1 = 2'b00;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        act = (|pp0) || (|rp0) || ae0 || (bo0 !== prev0) ||
              (|pp1) || (|rp1) || ae1 || (bo1 !== prev1);
        if (act) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_event: cyc=%0d al bo=%b pp=%b rp=%b ae=%b ah bo=%b pp=%b rp=%b ae=%b, want none",
                     cyc, bo0, pp0, rp0, ae0, bo1, pp1, rp1, ae1);
          end else begin
            e = sb.pop_front();
            chk_ev("event_al", e, cyc, bo0, pp0, rp0, ae0);
            chk_ev("event_ah", e, cyc, bo1, pp1, rp1, ae1);
          end
        end
        prev0 = bo0;
        prev1 = bo1;
      end
    end
  end

  initial begin : stim
    int t;
    vectors     = 0;
    miscompares = 0;
    mon_en      = 1'b0;
    reset_n     = 1'b0;
    key_al      = 2'b11;

    // 1: reset, idle pins, nothing may happen
    step(3);
    chk_zero("reset_state");
    mon_en = 1'b1;
    reset_n = 1'b1;
    step(20);
    chk_zero("idle_20_cycles");

    // 2: clean press and release on key 0
    key_al[0] = 1'b0;
    expect_ev(cyc + 6, 2'b01, 2'b01, 2'b00, 1'b1);
    step(10);
    key_al[0] = 1'b1;
    expect_ev(cyc + 6, 2'b00, 2'b00, 2'b01, 1'b1);
    step(10);

    // 3: bouncing key 1; only the final stable low counts
    key_al[1] = 1'b0; step(3);
    key_al[1] = 1'b1; step(1);
    key_al[1] = 1'b0; step(2);
    key_al[1] = 1'b1; step(1);
    key_al[1] = 1'b0;
    expect_ev(cyc + 6, 2'b10, 2'b10, 2'b00, 1'b1);
    step(10);
    key_al[1] = 1'b1;
    expect_ev(cyc + 6, 2'b00, 2'b00, 2'b10, 1'b1);
    step(10);

    // 4: both keys together
    key_al = 2'b00;
    expect_ev(cyc + 6, 2'b11, 2'b11, 2'b00, 1'b1);
    step(10);
    key_al = 2'b11;
    expect_ev(cyc + 6, 2'b00, 2'b00, 2'b11, 1'b1);
    step(10);

    // 5: async reset mid-count, with key 1 already accepted
    key_al[1] = 1'b0;
    expect_ev(cyc + 6, 2'b10, 2'b10, 2'b00, 1'b1);
    step(10);
    key_al[0] = 1'b0;
    step(4);
    expect_ev(cyc, 2'b00, 2'b00, 2'b00, 1'b0);
    reset_n = 1'b0;
    #1;
    chk_zero("async_reset_immediate");
    key_al[1] = 1'b1;
    step(2);
    chk_zero("held_in_reset");
    reset_n = 1'b1;
    expect_ev(cyc + 6, 2'b01, 2'b01, 2'b00, 1'b1);
    step(10);
    key_al[0] = 1'b1;
    expect_ev(cyc + 6, 2'b00, 2'b00, 2'b01, 1'b1);
    step(10);

    // short 3-cycle press never passes
    key_al[0] = 1'b0; step(3);
    key_al[0] = 1'b1; step(10);
    chk_zero("short_pulse_rejected");

    while (sb.size() != 0) begin
      ev_t e;
      e = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_event: got no event, want cyc=%0d bo=%b pp=%b rp=%b ae=%b",
               e.cyc, e.bo, e.pp, e.rp, e.ae);
    end
    t = vectors;
    $display("== %0d vectors applied, %0d miscompares ==", t, miscompares);
    $finish;
  end

endmodule
